// File: rtl/vec_mem_pkg.sv
// Shared layout of the dotProduct vector memory: element width, vector geometry
// and the state encoding of the read-side pair fetcher.
package vec_mem_pkg;

  localparam int DATA_WIDTH        = 8;
  localparam int NUMBER_OF_VECTORS = 4;
  localparam int VEC_LEN           = 8;
  localparam int DEPTH             = VEC_LEN * NUMBER_OF_VECTORS;
  localparam int ADDR_WIDTH        = 5;
  localparam int IDX_WIDTH         = 2;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_RD_A_ENC   = 3'd1;
  localparam logic [2:0] ST_RD_B_ENC   = 3'd2;
  localparam logic [2:0] ST_WAIT_B_ENC = 3'd3;
  localparam logic [2:0] ST_OUT_ENC    = 3'd4;
  localparam logic [2:0] ST_DONE_ENC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_RD_A   = ST_RD_A_ENC,
    ST_RD_B   = ST_RD_B_ENC,
    ST_WAIT_B = ST_WAIT_B_ENC,
    ST_OUT    = ST_OUT_ENC,
    ST_DONE   = ST_DONE_ENC
  } fetch_state_e;

endpackage

// File: rtl/vector_pair_fetch_if.sv
// Memory read port plus the (A[i], B[i]) pair stream of the vector pair fetcher.
// Pair stream: a pair transfers on a rising edge where out_valid && out_ready; once
// out_valid is high, out_a/out_b/out_last hold until that transfer. out_ready has no
// effect while out_valid is low. rd_data is valid the cycle after rd_en is sampled.
interface vector_pair_fetch_if #(
  parameter int DATA_WIDTH = vec_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = vec_mem_pkg::ADDR_WIDTH
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic                  out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_a, out_b, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_a, out_b, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/vector_pair_fetch.sv
// Fetches vectors A and B element by element from the vector memory and streams
// aligned (A[i], B[i]) pairs to the MAC. All outputs come straight from flops.
module vector_pair_fetch #(
  parameter int DATA_WIDTH        = vec_mem_pkg::DATA_WIDTH,
  parameter int NUMBER_OF_VECTORS = vec_mem_pkg::NUMBER_OF_VECTORS,
  parameter int VEC_LEN           = vec_mem_pkg::VEC_LEN,
  parameter int DEPTH             = VEC_LEN * NUMBER_OF_VECTORS,
  parameter int ADDR_WIDTH        = vec_mem_pkg::ADDR_WIDTH,
  parameter int IDX_WIDTH         = vec_mem_pkg::IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] vec_a_idx,
  input  logic [IDX_WIDTH-1:0] vec_b_idx,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state,
  vector_pair_fetch_if.master  bus
);

  import vec_mem_pkg::*;

  localparam int CNT_WIDTH = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0]  LAST_IDX  = CNT_WIDTH'(VEC_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] VEC_LEN_A = ADDR_WIDTH'(VEC_LEN);

  fetch_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  i_q, i_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
  logic [DATA_WIDTH-1:0] out_b_q, out_b_d;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_a_d = ADDR_WIDTH'(vec_a_idx) * VEC_LEN_A;
          base_b_d = ADDR_WIDTH'(vec_b_idx) * VEC_LEN_A;
          i_d      = '0;
          state_d  = ST_RD_A;
        end
      end
      ST_RD_A:   state_d = ST_RD_B;
      ST_RD_B: begin
        out_a_d = bus.rd_data;
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        out_b_d = bus.rd_data;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        // In OUT the registered out_valid is high, so out_ready alone completes the transfer.
        if (bus.out_ready) begin
          if (i_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            i_d     = i_q + CNT_WIDTH'(1);
            state_d = ST_RD_A;
          end
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    rd_en_d     = (state_d == ST_RD_A) || (state_d == ST_RD_B);
    out_valid_d = (state_d == ST_OUT);
    out_last_d  = (state_d == ST_OUT) && (i_d == LAST_IDX);
    rd_addr_d   = rd_addr_q;
    if (state_d == ST_RD_A) begin
      rd_addr_d = base_a_d + ADDR_WIDTH'(i_d);
    end else if (state_d == ST_RD_B) begin
      rd_addr_d = base_b_d + ADDR_WIDTH'(i_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;

endmodule

// File: tb/tb_vector_pair_fetch.sv
// Bench for vector_pair_fetch: preloaded memory model (data = addr + 0xA0), directed
// start commands, and queue-based scoreboards for pairs and read addresses.
module tb_vector_pair_fetch;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int W  = 2 * DW + 1;
  localparam int VL = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] vec_a_idx;
  logic [1:0] vec_b_idx;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  vector_pair_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  vector_pair_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_a_idx (vec_a_idx),
    .vec_b_idx (vec_b_idx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  logic [DW-1:0] mem [32];
  logic [W-1:0]  exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            n_checks;
  int            n_errors;
  int            pairs_seen;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s got=%0h required=%0h at %0t", name, got, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] elem(input int v, input int i);
    return DW'(v * VL + i + 'hA0);
  endfunction

  task automatic push_expected(input int a, input int b, input int n_pairs, input int n_reads);
    for (int i = 0; i < n_pairs; i++) begin
      exp_q.push_back({(i == VL - 1) ? 1'b1 : 1'b0, elem(a, i), elem(b, i)});
    end
    for (int i = 0; i < n_reads; i++) begin
      addr_q.push_back(AW'(a * VL + i));
      addr_q.push_back(AW'(b * VL + i));
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pair_unexpected got a=%0h b=%0h required=no pair", bus.out_a, bus.out_b);
        end else begin
          check("pair", 32'({bus.out_last, bus.out_a, bus.out_b}), 32'(exp_q.pop_front()));
        end
        pairs_seen++;
      end
      if (bus.rd_en) begin
        if (addr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_addr_unexpected got=%0d required=no read", bus.rd_addr);
        end else begin
          check("rd_addr", 32'(bus.rd_addr), 32'(addr_q.pop_front()));
        end
      end
    end
  end

  // Runs one full command; caller is just after a rising edge with the block idle.
  task automatic run_vector(input int a, input int b, input int stall_pair,
                            input int ign_cyc, input bit ign_done, input int exp_done);
    int cyc;
    int first_valid;
    int done_cyc;
    int base;
    bit stalled;
    base        = pairs_seen;
    stalled     = 1'b0;
    first_valid = -1;
    done_cyc    = -1;
    push_expected(a, b, VL, VL);
    vec_a_idx = 2'(a);
    vec_b_idx = 2'(b);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (done_cyc < 0 && cyc < 200) begin
      start = (cyc == ign_cyc) || (ign_done && cyc == exp_done);
      if (start) begin
        vec_a_idx = 2'd1;
        vec_b_idx = 2'd1;
      end
      if (stall_pair >= 0 && !stalled && (pairs_seen - base) == stall_pair) bus.out_ready = 1'b0;
      if (!bus.out_ready && bus.out_valid) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_rd_en", 32'(bus.rd_en), 32'd0);
          check("stall_a", 32'(bus.out_a), 32'(elem(a, stall_pair)));
          check("stall_b", 32'(bus.out_b), 32'(elem(b, stall_pair)));
          check("stall_last", 32'(bus.out_last), 32'd0);
          @(posedge clk);
          #1;
          cyc++;
        end
        bus.out_ready = 1'b1;
        stalled       = 1'b1;
      end
      @(negedge clk);
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check("first_valid_cycle", 32'(first_valid), 32'd4);
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("busy_at_done", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_pulse_width", 32'(done), 32'd0);
    check("state_idle_after_done", 32'(dbg_state), 32'd0);
  endtask

  // Asserts reset asynchronously while pair 4 is being presented.
  task automatic reset_mid(input int a, input int b);
    int cyc;
    push_expected(a, b, 4, 5);
    vec_a_idx = 2'(a);
    vec_b_idx = 2'(b);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_a", 32'(bus.out_a), 32'(elem(a, 4)));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_a", 32'(bus.out_a), 32'd0);
    check("rst_b", 32'(bus.out_b), 32'd0);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_pairs_left", 32'(exp_q.size()), 32'd0);
    check("rst_reads_left", 32'(addr_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver
  initial begin
    n_checks      = 0;
    n_errors      = 0;
    pairs_seen    = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    vec_a_idx     = 2'd0;
    vec_b_idx     = 2'd0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) mem[k] = DW'(k + 'hA0);

    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd_en", 32'(bus.rd_en), 32'd0);
    check("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_last", 32'(bus.out_last), 32'd0);
    check("reset_a", 32'(bus.out_a), 32'd0);
    check("reset_b", 32'(bus.out_b), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vector(0, 1, -1, -1, 1'b0, 33);
    run_vector(0, 1, 3, -1, 1'b0, 38);
    run_vector(3, 0, -1, -1, 1'b0, 33);
    run_vector(2, 2, -1, -1, 1'b0, 33);
    run_vector(0, 1, -1, 10, 1'b1, 33);
    run_vector(2, 3, -1, -1, 1'b0, 33);
    reset_mid(2, 3);
    run_vector(1, 2, -1, -1, 1'b0, 33);

    repeat (3) @(posedge clk);
    check("pairs_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(addr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
